// File: rtl/ppg_sample_processor.sv
// ppg_sample_processor
// Windowed statistics for a two-channel (RED / IR) PPG front end. Each
// channel collects N = 2^WIN_LOG2 samples. Per channel the block tracks the
// minimum, the maximum and the sum of the samples. When both windows are
// full it reports:
//   AC = max - min
//   DC = mean (truncated)
// It then holds the result until the consumer takes it.
//
// Ports
//   CLK        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = process samples, 0 = idle / abandon partial window
//   smp_valid  in   sample strobe, one sample per high cycle
//   smp_ch     in   sample channel, 0 = RED, 1 = IR
//   smp_data   in   8-bit unsigned ADC sample
//   res_ready  in   result consumer ready
//   ovr_clr    in   clears the sticky overrun flag
//   res_valid  out  result valid (held until res_valid && res_ready)
//   red_ac     out  RED max - min
//   red_dc     out  RED mean
//   ir_ac      out  IR max - min
//   ir_dc      out  IR mean
//   overrun    out  sticky: a sample was dropped
//   busy       out  high whenever the FSM is not IDLE
module ppg_sample_processor #(
  parameter int WIN_LOG2 = 6
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       smp_valid,
  input  logic       smp_ch,
  input  logic [7:0] smp_data,
  input  logic       res_ready,
  input  logic       ovr_clr,
  output logic       res_valid,
  output logic [7:0] red_ac,
  output logic [7:0] red_dc,
  output logic [7:0] ir_ac,
  output logic [7:0] ir_dc,
  output logic       overrun,
  output logic       busy
);

  localparam int SUM_W = 8 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int unsigned N_INT = 32'd1 << WIN_LOG2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_INT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t state_r;

  // Per-channel window state, index 0 = RED, 1 = IR
  logic [7:0]       min_r [2];
  logic [7:0]       max_r [2];
  logic [SUM_W-1:0] sum_r [2];
  logic [CNT_W-1:0] cnt_r [2];

  logic sel_full_s;
  logic both_full_s;
  logic accept_s;
  logic drop_s;
  logic clear_win_s;
  logic handshake_s;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Difference is clamped at zero so an empty window can never wrap
  function automatic logic [7:0] ac_of(input logic [7:0] mx, input logic [7:0] mn);
    return (mx >= mn) ? (mx - mn) : 8'd0;
  endfunction

  // Mean of a full window: the sum shifted right by WIN_LOG2, which always fits 8 bits
  function automatic logic [7:0] dc_of(input logic [SUM_W-1:0] s);
    return s[WIN_LOG2 +: 8];
  endfunction

  // Decode sample acceptance / drop and window clearing for the current state
  always_comb begin
    sel_full_s  = (cnt_r[smp_ch] == CNT_FULL);
    both_full_s = (cnt_r[0] == CNT_FULL) && (cnt_r[1] == CNT_FULL);
    handshake_s = res_valid && res_ready;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    clear_win_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_win_s = 1'b1;
      end
      ST_ACCUM: begin
        if (!enable) begin
          clear_win_s = 1'b1;
        end else begin
          clear_win_s = 1'b0;
        end
        if (smp_valid) begin
          if (sel_full_s) begin
            drop_s = 1'b1;
          end else begin
            accept_s = enable;
          end
        end else begin
          drop_s = 1'b0;
        end
      end
      ST_REPORT: begin
        // Results are frozen here; every incoming sample is lost
        drop_s      = smp_valid;
        clear_win_s = handshake_s;
      end
      default: begin
        clear_win_s = 1'b1;
      end
    endcase
  end

  // Window accumulators: reset/clear to init values, otherwise absorb accepted samples
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        min_r[i] <= 8'd255;
        max_r[i] <= 8'd0;
        sum_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else if (clear_win_s) begin
      for (int i = 0; i < 2; i++) begin
        min_r[i] <= 8'd255;
        max_r[i] <= 8'd0;
        sum_r[i] <= '0;
        cnt_r[i] <= '0;
      end
    end else if (accept_s) begin
      min_r[smp_ch] <= min8(min_r[smp_ch], smp_data);
      max_r[smp_ch] <= max8(max_r[smp_ch], smp_data);
      sum_r[smp_ch] <= sum_r[smp_ch] + SUM_W'(smp_data);
      cnt_r[smp_ch] <= cnt_r[smp_ch] + CNT_W'(1);
    end else begin
      min_r <= min_r;
      max_r <= max_r;
      sum_r <= sum_r;
      cnt_r <= cnt_r;
    end
  end

  // Control FSM with registered result, valid, busy and overrun outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      red_ac    <= 8'd0;
      red_dc    <= 8'd0;
      ir_ac     <= 8'd0;
      ir_dc     <= 8'd0;
    end else begin
      // A drop in the same cycle as a clear request keeps the flag set
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end

      case (state_r)
        ST_IDLE: begin
          res_valid <= 1'b0;
          if (enable) begin
            state_r <= ST_ACCUM;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_ACCUM: begin
          res_valid <= 1'b0;
          if (!enable) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (both_full_s) begin
            // Counts became full on the previous edge; publish the result now
            state_r   <= ST_REPORT;
            busy      <= 1'b1;
            res_valid <= 1'b1;
            red_ac    <= ac_of(max_r[0], min_r[0]);
            red_dc    <= dc_of(sum_r[0]);
            ir_ac     <= ac_of(max_r[1], min_r[1]);
            ir_dc     <= dc_of(sum_r[1]);
          end else begin
            state_r <= ST_ACCUM;
            busy    <= 1'b1;
          end
        end
        ST_REPORT: begin
          // enable is only looked at once the consumer has taken the result
          if (handshake_s) begin
            res_valid <= 1'b0;
            if (enable) begin
              state_r <= ST_ACCUM;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            res_valid <= 1'b1;
            state_r   <= ST_REPORT;
            busy      <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppg_sample_processor.sv
// Scoreboard bench for ppg_sample_processor with WIN_LOG2 = 2 (N = 4).
// The stimulus process pushes the hand-computed result of each window.
// The monitor pops an entry on every result handshake and compares it.
module tb_ppg_sample_processor;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       smp_valid = 1'b0;
  logic       smp_ch = 1'b0;
  logic [7:0] smp_data = 8'd0;
  logic       res_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       res_valid;
  logic [7:0] red_ac, red_dc, ir_ac, ir_dc;
  logic       overrun;
  logic       busy;

  typedef struct {
    logic [7:0] ra;
    logic [7:0] rd;
    logic [7:0] ia;
    logic [7:0] id;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ppg_sample_processor #(.WIN_LOG2(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .smp_valid(smp_valid),
    .smp_ch(smp_ch), .smp_data(smp_data), .res_ready(res_ready),
    .ovr_clr(ovr_clr), .res_valid(res_valid), .red_ac(red_ac),
    .red_dc(red_dc), .ir_ac(ir_ac), .ir_dc(ir_dc), .overrun(overrun),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp(input logic ch, input logic [7:0] d);
    smp_valid = 1'b1;
    smp_ch    = ch;
    smp_data  = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    res_t e;
    e.ra = a; e.rd = b; e.ia = c; e.id = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted result must match the oldest expectation
  always @(negedge CLK) begin : monitor
    res_t e;
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got red_ac=%0d red_dc=%0d ir_ac=%0d ir_dc=%0d required none",
                 red_ac, red_dc, ir_ac, ir_dc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_red_ac", red_ac, e.ra);
        chk("sb_red_dc", red_dc, e.rd);
        chk("sb_ir_ac",  ir_ac,  e.ia);
        chk("sb_ir_dc",  ir_dc,  e.id);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_overrun", {7'd0, overrun}, 8'd0);
    chk("rst_red_ac", red_ac, 8'd0);
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("busy_after_enable", {7'd0, busy}, 8'd1);

    // Interleaved window, consumer always ready
    push(8'd60, 8'd130, 8'd0, 8'd50);
    smp(1'b0, 8'd100); smp(1'b1, 8'd50); smp(1'b0, 8'd140); smp(1'b1, 8'd50);
    smp(1'b0, 8'd120); smp(1'b1, 8'd50); smp(1'b0, 8'd160); smp(1'b1, 8'd50);
    chk("t1_valid_not_early", {7'd0, res_valid}, 8'd0);
    tick();
    chk("t1_valid_latency", {7'd0, res_valid}, 8'd1);
    chk("t1_overrun", {7'd0, overrun}, 8'd0);
    tick();
    chk("t1_valid_drop", {7'd0, res_valid}, 8'd0);

    // Back-pressure: result held while samples arrive and get dropped
    res_ready = 1'b0;
    push(8'd30, 8'd25, 8'd0, 8'd5);
    smp(1'b0, 8'd10); smp(1'b1, 8'd5); smp(1'b0, 8'd20); smp(1'b1, 8'd5);
    smp(1'b0, 8'd30); smp(1'b1, 8'd5); smp(1'b0, 8'd40); smp(1'b1, 8'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {7'd0, res_valid}, 8'd1);
      chk("t2_hold_red_ac", red_ac, 8'd30);
      chk("t2_hold_red_dc", red_dc, 8'd25);
      chk("t2_hold_ir_ac", ir_ac, 8'd0);
      chk("t2_hold_ir_dc", ir_dc, 8'd5);
      if (i == 1 || i == 2) begin
        smp_valid = 1'b1; smp_ch = 1'b0; smp_data = 8'd99;
      end else begin
        smp_valid = 1'b0;
      end
      tick();
    end
    smp_valid = 1'b0;
    chk("t2_overrun_set", {7'd0, overrun}, 8'd1);
    chk("t2_hold_final", {7'd0, res_valid}, 8'd1);
    res_ready = 1'b1;
    tick();
    chk("t2_valid_drop", {7'd0, res_valid}, 8'd0);
    chk("t2_retained_red_ac", red_ac, 8'd30);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("t2_overrun_clr", {7'd0, overrun}, 8'd0);

    // Extremes: no sum overflow, full-scale AC
    push(8'd0, 8'd255, 8'd255, 8'd127);
    smp(1'b0, 8'd255); smp(1'b1, 8'd0); smp(1'b0, 8'd255); smp(1'b1, 8'd255);
    smp(1'b0, 8'd255); smp(1'b1, 8'd0); smp(1'b0, 8'd255); smp(1'b1, 8'd255);
    tick();
    chk("t3_valid", {7'd0, res_valid}, 8'd1);
    tick();

    // Fifth RED sample is dropped; IR completes the window
    push(8'd30, 8'd25, 8'd3, 8'd2);
    smp(1'b0, 8'd10); smp(1'b0, 8'd20); smp(1'b0, 8'd30); smp(1'b0, 8'd40);
    chk("t4_no_overrun_yet", {7'd0, overrun}, 8'd0);
    smp(1'b0, 8'd250);
    chk("t4_overrun_5th_red", {7'd0, overrun}, 8'd1);
    smp(1'b1, 8'd1); smp(1'b1, 8'd2); smp(1'b1, 8'd3); smp(1'b1, 8'd4);
    tick();
    chk("t4_valid", {7'd0, res_valid}, 8'd1);
    tick();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("t4_overrun_clr", {7'd0, overrun}, 8'd0);

    // Partial window abandoned by dropping enable
    smp(1'b0, 8'd200); smp(1'b0, 8'd200); smp(1'b1, 8'd200);
    enable = 1'b0;
    tick();
    chk("t5_busy_idle", {7'd0, busy}, 8'd0);
    chk("t5_no_result", {7'd0, res_valid}, 8'd0);
    enable = 1'b1;
    tick();
    chk("t5_busy_accum", {7'd0, busy}, 8'd1);
    push(8'd3, 8'd2, 8'd0, 8'd8);
    smp(1'b0, 8'd1); smp(1'b1, 8'd8); smp(1'b0, 8'd2); smp(1'b1, 8'd8);
    smp(1'b0, 8'd3); smp(1'b1, 8'd8); smp(1'b0, 8'd4); smp(1'b1, 8'd8);
    tick();
    chk("t5_valid", {7'd0, res_valid}, 8'd1);
    tick();

    // Asynchronous reset mid-window
    smp(1'b0, 8'd7); smp(1'b1, 8'd0); smp(1'b0, 8'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("t6_rst_busy", {7'd0, busy}, 8'd0);
    chk("t6_rst_overrun", {7'd0, overrun}, 8'd0);
    chk("t6_rst_red_ac", red_ac, 8'd0);
    chk("t6_rst_red_dc", red_dc, 8'd0);
    chk("t6_rst_ir_dc", ir_dc, 8'd0);
    rst_n = 1'b1;
    tick();
    chk("t6_busy_after_rst", {7'd0, busy}, 8'd1);
    push(8'd2, 8'd7, 8'd200, 8'd85);
    smp(1'b0, 8'd7); smp(1'b1, 8'd0); smp(1'b0, 8'd7); smp(1'b1, 8'd100);
    smp(1'b0, 8'd7); smp(1'b1, 8'd200); smp(1'b0, 8'd9); smp(1'b1, 8'd40);
    tick();
    chk("t6_valid", {7'd0, res_valid}, 8'd1);
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending results expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
